ice51_loader: RTL and testbench

UART boot loader that sits between the board UART RX pin and the ice51 code memory. It deserialises 8N1 bytes at 115200 baud from a 12 MHz clock. It writes them sequentially into code memory from address 0 and, once MEM_SIZE bytes have landed, releases the ice51 core via `o_core_run`. The core's UART TX path is unaffected; this block is upstream of the core and code memory only.

---
 rtl/ice51_loader_if.sv | 11 +
 rtl/ice51_loader.sv | 156 +++++++++++++++
 tb/tb_ice51_loader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ice51_loader_if.sv
// Code-memory write port of the ice51 boot loader.
interface ice51_loader_if #(
   parameter int ADDR_W = 9
);
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;

   modport master (output mem_we, mem_addr, mem_data);
   modport slave  (input  mem_we, mem_addr, mem_data);
endinterface

// File: rtl/ice51_loader.sv
// UART 8N1 boot loader: fills ice51 code memory from address 0, then releases the core.
// Optional trailing checksum byte enabled by ICE51_LOADER_CHECKSUM_EN.
module ice51_loader #(
   parameter int CLKS_PER_BIT = 104,
   parameter int MEM_SIZE     = 512,
   parameter int ADDR_W       = 9
) (
   input  logic           i_clk,
   input  logic           i_nrst,
   input  logic           i_uart_rx,
   ice51_loader_if.master mem,
   output logic           o_core_run,
   output logic           o_err
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_SIZE - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   logic              rx_s1, rx_s2;
   logic [2:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic              byte_vld;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              core_run;

   // Idle-high line: synchroniser resets to 1 so reset release never looks like a start edge.
   always_ff @(posedge i_clk or posedge i_nrst) begin
      if (i_nrst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= i_uart_rx;
         rx_s2 <= rx_s1;
      end
   end

   assign byte_vld = (state == S_STOP) && (cnt == CNT_FULL) && rx_s2;

   always_ff @(posedge i_clk or posedge i_nrst) begin
      if (i_nrst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!rx_s2) begin
                  state   <= S_START;
                  cnt     <= '0;
                  bit_idx <= '0;
               end
            end
            S_START: begin
               if (cnt == CNT_HALF) begin
                  cnt   <= '0;
                  state <= rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt == CNT_FULL) begin
                  cnt     <= '0;
                  shreg   <= {rx_s2, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (cnt == CNT_FULL) begin
                  cnt   <= '0;
                  state <= rx_s2 ? S_IDLE : S_WAIT_HIGH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WAIT_HIGH: begin
               if (rx_s2) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ICE51_LOADER_CHECKSUM_EN
   logic [7:0] sum;
   logic       sum_phase;
   logic       err;

   always_ff @(posedge i_clk or posedge i_nrst) begin
      if (i_nrst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_data  <= '0;
         core_run  <= 1'b0;
         sum       <= '0;
         sum_phase <= 1'b0;
         err       <= 1'b0;
      end else if (mem_we) begin
         mem_we <= 1'b0;
         if (mem_addr == ADDR_LAST) sum_phase <= 1'b1;
         else                       mem_addr  <= mem_addr + 1'b1;
      end else if (byte_vld && !core_run && !err) begin
         // After the last data byte the next byte is the checksum, never written.
         if (sum_phase) begin
            if (shreg == sum) core_run <= 1'b1;
            else              err      <= 1'b1;
         end else begin
            mem_we   <= 1'b1;
            mem_data <= shreg;
            sum      <= sum + shreg;
         end
      end
   end

   assign o_err = err;
`else
   always_ff @(posedge i_clk or posedge i_nrst) begin
      if (i_nrst) begin
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
         core_run <= 1'b0;
      end else if (mem_we) begin
         // Address saturates on the final byte; run releases as the strobe drops.
         mem_we <= 1'b0;
         if (mem_addr == ADDR_LAST) core_run <= 1'b1;
         else                       mem_addr <= mem_addr + 1'b1;
      end else if (byte_vld && !core_run) begin
         mem_we   <= 1'b1;
         mem_data <= shreg;
      end
   end

   assign o_err = 1'b0;
`endif

   assign mem.mem_we   = mem_we;
   assign mem.mem_addr = mem_addr;
   assign mem.mem_data = mem_data;
   assign o_core_run   = core_run;
endmodule

// File: tb/tb_ice51_loader.sv
// Directed bench for ice51_loader with a shortened bit time to keep full loads fast.
module tb_ice51_loader;
   localparam int CPB      = 4;
   localparam int MEM_SIZE = 512;
   localparam int ADDR_W   = 9;

   logic i_clk = 1'b0;
   logic i_nrst = 1'b0;
   logic i_uart_rx = 1'b1;
   logic o_core_run, o_err;

   ice51_loader_if #(.ADDR_W(ADDR_W)) mem_if ();

   ice51_loader #(.CLKS_PER_BIT(CPB), .MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
      .i_clk      (i_clk),
      .i_nrst     (i_nrst),
      .i_uart_rx  (i_uart_rx),
      .mem        (mem_if),
      .o_core_run (o_core_run),
      .o_err      (o_err)
   );

   always #5 i_clk = ~i_clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_we_cyc = 0;
   int run_cyc = 0;
   bit run_seen = 0;
   logic [ADDR_W-1:0] log_addr[$];
   logic [7:0]        log_data[$];

   // Write-strobe monitor, sampled on the falling edge.
   always @(negedge i_clk) begin
      cyc = cyc + 1;
      if (mem_if.mem_we === 1'b1) begin
         log_addr.push_back(mem_if.mem_addr);
         log_data.push_back(mem_if.mem_data);
         last_we_cyc = cyc;
      end
      if (o_core_run === 1'b1 && !run_seen) begin
         run_seen = 1;
         run_cyc  = cyc;
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge i_clk);
      i_uart_rx = 1'b0;
      repeat (CPB) @(negedge i_clk);
      for (int i = 0; i < 8; i++) begin
         i_uart_rx = b[i];
         repeat (CPB) @(negedge i_clk);
      end
      i_uart_rx = stop_bit;
      repeat (CPB - 1) @(negedge i_clk);
   endtask

   task automatic pulse_reset(input int n);
      @(negedge i_clk);
      i_uart_rx = 1'b1;
      i_nrst = 1'b1;
      repeat (n) @(negedge i_clk);
      i_nrst = 1'b0;
      log_addr.delete();
      log_data.delete();
      run_seen = 0;
      repeat (2) @(negedge i_clk);
   endtask

   task automatic test_reset;
      i_nrst = 1'b1;
      repeat (100) @(negedge i_clk);
      n_cmp++; if (mem_if.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", mem_if.mem_we); end
      n_cmp++; if (mem_if.mem_addr !== 9'h000) begin n_bad++; $display("FAIL rst_addr: got %h want 000", mem_if.mem_addr); end
      n_cmp++; if (mem_if.mem_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", mem_if.mem_data); end
      n_cmp++; if (o_core_run !== 1'b0) begin n_bad++; $display("FAIL rst_run: got %b want 0", o_core_run); end
      n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", o_err); end
      i_nrst = 1'b0;
      log_addr.delete();
      log_data.delete();
      repeat (10000) @(negedge i_clk);
      n_cmp++; if (log_addr.size() !== 0) begin n_bad++; $display("FAIL idle_writes: got %0d want 0", log_addr.size()); end
      n_cmp++; if (mem_if.mem_addr !== 9'h000) begin n_bad++; $display("FAIL idle_addr: got %h want 000", mem_if.mem_addr); end
      n_cmp++; if (o_core_run !== 1'b0) begin n_bad++; $display("FAIL idle_run: got %b want 0", o_core_run); end
   endtask

   task automatic test_single_byte;
      send_byte(8'hA5, 1'b1);
      repeat (5) @(negedge i_clk);
      n_cmp++; if (log_addr.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", log_addr.size()); end
      if (log_addr.size() >= 1) begin
         n_cmp++; if (log_addr[0] !== 9'h000) begin n_bad++; $display("FAIL single_addr: got %h want 000", log_addr[0]); end
         n_cmp++; if (log_data[0] !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", log_data[0]); end
      end
      n_cmp++; if (mem_if.mem_addr !== 9'h001) begin n_bad++; $display("FAIL single_next_addr: got %h want 001", mem_if.mem_addr); end
   endtask

   task automatic test_glitch;
      int n0;
      n0 = log_addr.size();
      @(negedge i_clk);
      i_uart_rx = 1'b0;
      @(negedge i_clk);
      i_uart_rx = 1'b1;
      repeat (20 * CPB) @(negedge i_clk);
      n_cmp++; if (log_addr.size() !== n0) begin n_bad++; $display("FAIL glitch_writes: got %0d want %0d", log_addr.size(), n0); end
      n_cmp++; if (mem_if.mem_addr !== 9'h001) begin n_bad++; $display("FAIL glitch_addr: got %h want 001", mem_if.mem_addr); end
   endtask

   task automatic test_framing;
      int n0;
      n0 = log_addr.size();
      send_byte(8'h55, 1'b0);
      @(negedge i_clk);
      i_uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge i_clk);
      n_cmp++; if (log_addr.size() !== n0) begin n_bad++; $display("FAIL frame_writes: got %0d want %0d", log_addr.size(), n0); end
      n_cmp++; if (mem_if.mem_addr !== 9'h001) begin n_bad++; $display("FAIL frame_addr: got %h want 001", mem_if.mem_addr); end
      send_byte(8'h3C, 1'b1);
      repeat (5) @(negedge i_clk);
      n_cmp++; if (log_addr.size() !== n0 + 1) begin n_bad++; $display("FAIL frame_next_count: got %0d want %0d", log_addr.size(), n0 + 1); end
      if (log_addr.size() == n0 + 1) begin
         n_cmp++; if (log_addr[n0] !== 9'h001) begin n_bad++; $display("FAIL frame_next_addr: got %h want 001", log_addr[n0]); end
         n_cmp++; if (log_data[n0] !== 8'h3C) begin n_bad++; $display("FAIL frame_next_data: got %h want 3c", log_data[n0]); end
      end
   endtask

   task automatic test_reset_mid_load;
      pulse_reset(10);
      for (int i = 0; i < 100; i++) send_byte(8'(i), 1'b1);
      repeat (5) @(negedge i_clk);
      n_cmp++; if (log_addr.size() !== 100) begin n_bad++; $display("FAIL mid_count: got %0d want 100", log_addr.size()); end
      n_cmp++; if (mem_if.mem_addr !== 9'd100) begin n_bad++; $display("FAIL mid_addr: got %h want 064", mem_if.mem_addr); end
      pulse_reset(10);
      n_cmp++; if (mem_if.mem_addr !== 9'h000) begin n_bad++; $display("FAIL mid_rst_addr: got %h want 000", mem_if.mem_addr); end
      send_byte(8'h11, 1'b1);
      repeat (5) @(negedge i_clk);
      n_cmp++; if (log_addr.size() !== 1) begin n_bad++; $display("FAIL reload_count: got %0d want 1", log_addr.size()); end
      if (log_addr.size() == 1) begin
         n_cmp++; if (log_addr[0] !== 9'h000) begin n_bad++; $display("FAIL reload_addr: got %h want 000", log_addr[0]); end
         n_cmp++; if (log_data[0] !== 8'h11) begin n_bad++; $display("FAIL reload_data: got %h want 11", log_data[0]); end
      end
      n_cmp++; if (o_core_run !== 1'b0) begin n_bad++; $display("FAIL reload_run: got %b want 0", o_core_run); end
   endtask

   // Back-to-back load of byte[i] = i[7:0]; checksum of this pattern is 0x00.
   task automatic test_full_load;
      int bad_wr;
      pulse_reset(10);
      for (int i = 0; i < MEM_SIZE; i++) send_byte(8'(i), 1'b1);
      repeat (5) @(negedge i_clk);
      n_cmp++; if (log_addr.size() !== MEM_SIZE) begin n_bad++; $display("FAIL full_count: got %0d want %0d", log_addr.size(), MEM_SIZE); end
      bad_wr = 0;
      for (int i = 0; i < log_addr.size() && i < MEM_SIZE; i++) begin
         n_cmp++;
         if (log_addr[i] !== 9'(i) || log_data[i] !== 8'(i)) begin
            n_bad++;
            if (bad_wr < 4) $display("FAIL full_write[%0d]: got %h/%h want %h/%h", i, log_addr[i], log_data[i], 9'(i), 8'(i));
            bad_wr++;
         end
      end
      n_cmp++; if (mem_if.mem_addr !== 9'd511) begin n_bad++; $display("FAIL full_addr_sat: got %h want 1ff", mem_if.mem_addr); end
`ifdef ICE51_LOADER_CHECKSUM_EN
      n_cmp++; if (o_core_run !== 1'b0) begin n_bad++; $display("FAIL ck_run_before_sum: got %b want 0", o_core_run); end
      send_byte(8'h00, 1'b1);
      repeat (5) @(negedge i_clk);
      n_cmp++; if (o_core_run !== 1'b1) begin n_bad++; $display("FAIL ck_good_run: got %b want 1", o_core_run); end
      n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL ck_good_err: got %b want 0", o_err); end
      n_cmp++; if (log_addr.size() !== MEM_SIZE) begin n_bad++; $display("FAIL ck_sum_not_written: got %0d want %0d", log_addr.size(), MEM_SIZE); end
`else
      n_cmp++; if (o_core_run !== 1'b1) begin n_bad++; $display("FAIL full_run: got %b want 1", o_core_run); end
      n_cmp++; if (run_cyc !== last_we_cyc + 1) begin n_bad++; $display("FAIL full_run_timing: got cyc %0d want %0d", run_cyc, last_we_cyc + 1); end
      n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL full_err: got %b want 0", o_err); end
`endif
      send_byte(8'hEE, 1'b1);
      repeat (5) @(negedge i_clk);
      n_cmp++; if (log_addr.size() !== MEM_SIZE) begin n_bad++; $display("FAIL extra_write: got %0d want %0d", log_addr.size(), MEM_SIZE); end
      n_cmp++; if (mem_if.mem_addr !== 9'd511) begin n_bad++; $display("FAIL extra_addr: got %h want 1ff", mem_if.mem_addr); end
      n_cmp++; if (o_core_run !== 1'b1) begin n_bad++; $display("FAIL extra_run: got %b want 1", o_core_run); end
   endtask

`ifdef ICE51_LOADER_CHECKSUM_EN
   task automatic test_checksum_bad;
      pulse_reset(10);
      for (int i = 0; i < MEM_SIZE; i++) send_byte(8'(i), 1'b1);
      send_byte(8'h01, 1'b1);
      repeat (5) @(negedge i_clk);
      n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL ck_bad_err: got %b want 1", o_err); end
      n_cmp++; if (o_core_run !== 1'b0) begin n_bad++; $display("FAIL ck_bad_run: got %b want 0", o_core_run); end
      send_byte(8'h00, 1'b1);
      repeat (5) @(negedge i_clk);
      n_cmp++; if (o_core_run !== 1'b0 || o_err !== 1'b1) begin n_bad++; $display("FAIL ck_bad_sticky: got run %b err %b want 0 1", o_core_run, o_err); end
      n_cmp++; if (log_addr.size() !== MEM_SIZE) begin n_bad++; $display("FAIL ck_bad_writes: got %0d want %0d", log_addr.size(), MEM_SIZE); end
      pulse_reset(10);
      n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL ck_bad_err_clear: got %b want 0", o_err); end
   endtask
`endif

   initial begin
      test_reset;
      test_single_byte;
      test_glitch;
      test_framing;
      test_reset_mid_load;
      test_full_load;
`ifdef ICE51_LOADER_CHECKSUM_EN
      test_checksum_bad;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
